// File: rtl/modmul_rr_scheduler_if.sv
// Bus bundle between the modular-multiplier scheduler and its surroundings:
// requester ports, modulus configuration, multiplier datapath and responses.
interface modmul_rr_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [DATA_WIDTH-1:0]         cfg_modulus;
  logic [DATA_WIDTH-1:0]         mul_a;
  logic [DATA_WIDTH-1:0]         mul_b;
  logic [DATA_WIDTH-1:0]         mul_modulus;
  logic [DATA_WIDTH-1:0]         mul_result;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          busy;

  // Environment side: requesters, configuration master and the multiplier.
  modport master (
    output req_valid, req_a, req_b, cfg_valid, cfg_modulus, mul_result,
    input  req_ready, cfg_ready, mul_a, mul_b, mul_modulus,
           rsp_valid, rsp_id, rsp_data, busy
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, cfg_valid, cfg_modulus, mul_result,
    output req_ready, cfg_ready, mul_a, mul_b, mul_modulus,
           rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/modmul_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined Barrett multiplier among
// NUM_REQ requesters. Requester tags ride a shadow pipeline aligned with the
// multiplier result; modulus updates wait for the pipeline to drain.
module modmul_rr_scheduler #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1,
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input logic                 clk,
  input logic                 rst,
  modmul_rr_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(MUL_LATENCY + 2) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [ID_WIDTH-1:0]   rr_ptr_reg;
  logic [DATA_WIDTH-1:0] mul_a_reg;
  logic [DATA_WIDTH-1:0] mul_b_reg;
  logic [DATA_WIDTH-1:0] modulus_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  tag_valid_reg [MUL_LATENCY+1];
  logic [ID_WIDTH-1:0]   tag_id_reg    [MUL_LATENCY+1];

  logic [DATA_WIDTH-1:0] a_slice [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_slice [NUM_REQ];
  logic                  grant;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [NUM_REQ-1:0]    grant_onehot;
  logic                  cfg_ready;
  logic                  head_valid;
  logic [ID_WIDTH-1:0]   head_id;

  // Per-requester operand slices and one-hot decodes.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign a_slice[gi]      = bus.req_a[gi*DATA_WIDTH +: DATA_WIDTH];
    assign b_slice[gi]      = bus.req_b[gi*DATA_WIDTH +: DATA_WIDTH];
    assign grant_onehot[gi] = grant && (grant_id == ID_WIDTH'(gi));
    assign bus.rsp_valid[gi] = head_valid && (head_id == ID_WIDTH'(gi));
  end

  // Round-robin search starting just after the last winner; grants only in RUN
  // and never in the cycle a modulus update is requested.
  always_comb begin
    int cand;
    grant    = 1'b0;
    grant_id = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant && bus.req_valid[ID_WIDTH'(cand)]) begin
        grant    = 1'b1;
        grant_id = ID_WIDTH'(cand);
      end
    end
    if (rst || (state_reg != RUN) || bus.cfg_valid) begin
      grant    = 1'b0;
      grant_id = '0;
    end
  end

  // Modulus-update sequencing: stop issuing, wait for drain, load for one cycle.
  always_comb begin
    state_next = state_reg;
    cfg_ready  = 1'b0;
    case (state_reg)
      RUN:   if (bus.cfg_valid) state_next = DRAIN;
      DRAIN: begin
        if (!bus.cfg_valid)           state_next = RUN;
        else if (count_reg == '0)     state_next = LOAD;
      end
      LOAD: begin
        cfg_ready  = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  // Arbitration pointer, issue registers and the modulus register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg  <= ID_WIDTH'(NUM_REQ - 1);
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      modulus_reg <= '0;
    end else begin
      if (grant) begin
        rr_ptr_reg <= grant_id;
        mul_a_reg  <= a_slice[grant_id];
        mul_b_reg  <= b_slice[grant_id];
      end
      if (cfg_ready) modulus_reg <= bus.cfg_modulus;
    end
  end

  // Tag shadow pipeline: stage 0 sits beside the issue register, the last
  // stage lines up with mul_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= MUL_LATENCY; s++) begin
        tag_valid_reg[s] <= 1'b0;
        tag_id_reg[s]    <= '0;
      end
    end else begin
      tag_valid_reg[0] <= grant;
      tag_id_reg[0]    <= grant_id;
      for (int s = MUL_LATENCY; s > 0; s--) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

  // In-flight operation counter: up on grant, down on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      case ({grant, head_valid})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_valid      = tag_valid_reg[MUL_LATENCY];
  assign head_id         = tag_id_reg[MUL_LATENCY];
  assign bus.req_ready   = grant_onehot;
  assign bus.cfg_ready   = cfg_ready;
  assign bus.mul_a       = mul_a_reg;
  assign bus.mul_b       = mul_b_reg;
  assign bus.mul_modulus = modulus_reg;
  assign bus.rsp_id      = head_valid ? head_id : '0;
  assign bus.rsp_data    = head_valid ? bus.mul_result : '0;
  assign bus.busy        = (count_reg != '0);
endmodule

// File: tb/tb_modmul_rr_scheduler.sv
// Bench for modmul_rr_scheduler: a behavioural multiplier, a queue-based
// reference of expected responses, directed scenarios and a random phase.
module tb_modmul_rr_scheduler;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int ML = 1;
  localparam int IW = $clog2(NR);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modmul_rr_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

  modmul_rr_scheduler #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MUL_LATENCY(ML), .ID_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural pipelined modular multiplier, ML cycles from operands to result.
  logic [DW-1:0] mul_pipe [ML];
  always @(posedge clk) begin
    if (bus.mul_modulus == '0) mul_pipe[0] <= '0;
    else mul_pipe[0] <= DW'((32'(bus.mul_a) * 32'(bus.mul_b)) % 32'(bus.mul_modulus));
    for (int s = 1; s < ML; s++) mul_pipe[s] <= mul_pipe[s-1];
  end
  assign bus.mul_result = mul_pipe[ML-1];

  typedef struct {
    int id;
    int data;
    int due;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference state: pending responses, arbitration pointer, cfg phase, modulus.
  exp_t exp_q[$];
  int   ptr_m   = NR - 1;
  int   phase_m = 0;      // 0 issuing, 1 waiting for drain, 2 load cycle
  int   mod_m   = 0;
  int   last_a  = 0;
  int   last_b  = 0;

  logic [NR-1:0] seen_ready;
  logic          seen_cfg_ready;
  int grant_log[$];
  int rsp_ids[$];
  int rsp_datas[$];
  int rsp_cycs[$];

  bit            pv [NR];
  logic [DW-1:0] pa [NR];
  logic [DW-1:0] pb [NR];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe and check at negedge, advance the reference at posedge.
  task automatic tick();
    int            win;
    bit            g;
    bit            cv;
    logic [DW-1:0] cm;
    bit            cz;
    logic [NR-1:0] er;
    exp_t          e;
    int            av;
    int            bv;
    @(negedge clk);
    seen_ready     = bus.req_ready;
    seen_cfg_ready = bus.cfg_ready;
    for (int i = 0; i < NR; i++) if (bus.req_ready[i]) grant_log.push_back(i);
    if (bus.rsp_valid != '0) begin
      rsp_ids.push_back(int'(bus.rsp_id));
      rsp_datas.push_back(int'(bus.rsp_data));
      rsp_cycs.push_back(cyc);
      $display("rsp cyc=%0d id=%0d data=%0d", cyc, bus.rsp_id, bus.rsp_data);
    end
    g  = 1'b0;
    win = 0;
    cv = bus.cfg_valid;
    cm = bus.cfg_modulus;
    cz = (exp_q.size() == 0);
    if (!rst) begin
      check("cfg_ready", bus.cfg_ready, (phase_m == 2) ? 1 : 0);
      check("busy", bus.busy, (exp_q.size() != 0) ? 1 : 0);
      check("mul_modulus", bus.mul_modulus, mod_m);
      check("mul_a", bus.mul_a, last_a);
      check("mul_b", bus.mul_b, last_b);
      if (phase_m == 0 && !cv) begin
        for (int k = 1; k <= NR; k++) begin
          int idx;
          idx = (ptr_m + k) % NR;
          if (!g && bus.req_valid[idx]) begin
            g   = 1'b1;
            win = idx;
          end
        end
      end
      er = '0;
      if (g) er[win] = 1'b1;
      check("req_ready", bus.req_ready, er);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e  = exp_q.pop_front();
        er = '0;
        er[e.id] = 1'b1;
        check("rsp_valid", bus.rsp_valid, er);
        check("rsp_id", bus.rsp_id, e.id);
        check("rsp_data", bus.rsp_data, e.data);
      end else begin
        check("rsp_valid_idle", bus.rsp_valid, 0);
        check("rsp_id_idle", bus.rsp_id, 0);
      end
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      ptr_m = NR - 1; phase_m = 0; mod_m = 0; last_a = 0; last_b = 0;
    end else begin
      if (g) begin
        av = int'(bus.req_a[win*DW +: DW]);
        bv = int'(bus.req_b[win*DW +: DW]);
        e.id   = win;
        e.data = (mod_m == 0) ? 0 : (av * bv) % mod_m;
        e.due  = cyc + ML + 1;
        exp_q.push_back(e);
        ptr_m = win; last_a = av; last_b = bv;
      end
      if (phase_m == 2) begin
        mod_m = int'(cm);
        phase_m = 0;
      end else if (phase_m == 1) begin
        if (!cv) phase_m = 0;
        else if (cz) phase_m = 2;
      end else if (cv) begin
        phase_m = 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]         = pv[i];
      bus.req_a[i*DW +: DW]    = pa[i];
      bus.req_b[i*DW +: DW]    = pb[i];
    end
    tick();
    for (int i = 0; i < NR; i++) if (seen_ready[i]) pv[i] = 1'b0;
  endtask

  task automatic clear_logs();
    grant_log.delete(); rsp_ids.delete(); rsp_datas.delete(); rsp_cycs.delete();
  endtask

  task automatic cfg_load(input int m, output int lat);
    bus.cfg_valid   = 1'b1;
    bus.cfg_modulus = DW'(m);
    lat = -1;
    for (int n = 0; n < 30 && lat < 0; n++) begin
      step();
      if (seen_cfg_ready) lat = n;
    end
    bus.cfg_valid = 1'b0;
    check("cfg_ready_seen", seen_cfg_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    int ngr;
    int nrsp;
    bit cfg_act;
    int cfg_age;
    for (int i = 0; i < NR; i++) begin pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    bus.cfg_valid = 1'b0; bus.cfg_modulus = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_mul_a", bus.mul_a, 0);
    check("rst_mul_modulus", bus.mul_modulus, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_cfg_ready", bus.cfg_ready, 0);

    // Modulus load with an idle pipeline.
    cfg_load(255, lat);
    check("t1_cfg_latency", lat, 2);
    check("t1_modulus", bus.mul_modulus, 255);

    // Single request from requester 0.
    clear_logs();
    base = cyc;
    pv[0] = 1'b1; pa[0] = 8'd16; pb[0] = 8'd16;
    step();
    check("t2_ready", seen_ready, 4'b0001);
    repeat (4) step();
    check("t2_rsp_count", rsp_ids.size(), 1);
    check("t2_rsp_id", (rsp_ids.size() > 0) ? rsp_ids[0] : -1, 0);
    check("t2_rsp_data", (rsp_datas.size() > 0) ? rsp_datas[0] : -1, 1);
    check("t2_latency", (rsp_cycs.size() > 0) ? rsp_cycs[0] - base : -1, ML + 1);

    // Pointer at 1, then requesters 1 and 3 compete.
    pv[1] = 1'b1; pa[1] = 8'd1; pb[1] = 8'd1;
    step(); repeat (3) step();
    clear_logs();
    pv[1] = 1'b1; pa[1] = 8'd200; pb[1] = 8'd3;
    pv[3] = 1'b1; pa[3] = 8'd100; pb[3] = 8'd100;
    for (int n = 0; n < 10 && (pv[1] || pv[3]); n++) step();
    repeat (4) step();
    check("t4_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 3);
    check("t4_second_grant", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
    check("t4_first_data", (rsp_datas.size() > 0) ? rsp_datas[0] : -1, 55);
    check("t4_second_data", (rsp_datas.size() > 1) ? rsp_datas[1] : -1, 90);

    // Pointer at 3, then all four held valid for eight cycles.
    pv[3] = 1'b1; step(); repeat (3) step();
    clear_logs();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NR; i++) begin
        pv[i] = 1'b1; pa[i] = DW'($urandom_range(0, 255)); pb[i] = DW'($urandom_range(0, 255));
      end
      step();
    end
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      check("t3_grant_order", (i < grant_log.size()) ? grant_log[i] : -1, i % NR);
      check("t3_rsp_order", (i < rsp_ids.size()) ? rsp_ids[i] : -1, i % NR);
      check("t3_back_to_back", (i < rsp_cycs.size()) ? rsp_cycs[i] - rsp_cycs[0] : -1, i);
    end

    // Modulus change with two operations in flight.
    nrsp = rsp_ids.size();
    pv[0] = 1'b1; pa[0] = DW'($urandom_range(0, 255)); pb[0] = DW'($urandom_range(0, 255));
    pv[2] = 1'b1; pa[2] = DW'($urandom_range(0, 255)); pb[2] = DW'($urandom_range(0, 255));
    step(); step();
    ngr = grant_log.size();
    pv[1] = 1'b1; pa[1] = 8'd200; pb[1] = 8'd3;
    cfg_load(251, lat);
    check("t5_cfg_latency", lat, 3);
    check("t5_no_grant", grant_log.size() - ngr, 0);
    check("t5_drained", rsp_ids.size() - nrsp, 2);
    for (int n = 0; n < 10 && pv[1]; n++) step();
    repeat (3) step();
    check("t5_new_modulus", rsp_datas[rsp_datas.size()-1], 98);

    // Reset one cycle after a grant drops the operation.
    nrsp = rsp_ids.size();
    pv[0] = 1'b1; pa[0] = 8'd7; pb[0] = 8'd9;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_mul_a", bus.mul_a, 0);
    check("t6_mul_b", bus.mul_b, 0);
    check("t6_mul_modulus", bus.mul_modulus, 0);
    check("t6_busy", bus.busy, 0);
    repeat (4) step();
    check("t6_no_rsp", rsp_ids.size() - nrsp, 0);

    // Random traffic with occasional modulus updates.
    cfg_load(255, lat);
    cfg_act = 1'b0;
    cfg_age = 0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 40) begin
          pv[i] = 1'b1; pa[i] = DW'($urandom_range(0, 255)); pb[i] = DW'($urandom_range(0, 255));
        end
      end
      if (!cfg_act && $urandom_range(0, 99) < 3) begin
        cfg_act = 1'b1; cfg_age = 0;
        bus.cfg_valid = 1'b1; bus.cfg_modulus = DW'($urandom_range(1, 255));
      end
      step();
      if (cfg_act) begin
        cfg_age++;
        if (seen_cfg_ready) begin
          cfg_act = 1'b0; bus.cfg_valid = 1'b0;
        end else if (cfg_age > 40) begin
          check("cfg_ready_timeout", seen_cfg_ready, 1);
          cfg_act = 1'b0; bus.cfg_valid = 1'b0;
        end
      end
    end
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
    bus.cfg_valid = 1'b0;
    repeat (6) step();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
